// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state
// encoding and the bit-counter width.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // The counter must be able to hold WIDTH itself, hence WIDTH+1.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int CNT_W = cnt_w(DEFAULT_WIDTH);

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder used as the serial datapath of serial_add_unit.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial unsigned adder: latches a and b on start, adds one bit per
// cycle LSB first, and presents the WIDTH+1 bit sum with a done pulse.
module serial_add_unit
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   f
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t          state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sum_bit;
  logic             carry_out;

  fa_cell u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .sum  (sum_bit),
    .carry(carry_out)
  );

  // NOTE: all state uses non-blocking assignments so every flop samples
  // the pre-edge values, e.g. f below sees res before this edge's shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      f     <= '0;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          done <= 1'b0;
        end
        RUN: begin
          res   <= {sum_bit, res[WIDTH-1:1]};
          carry <= carry_out;
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          cnt   <= cnt + 1'b1;
          // On the last bit the fresh sum bit and carry bypass res/carry.
          if (cnt == LAST_BIT) begin
            f     <= {carry_out, sum_bit, res[WIDTH-1:1]};
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
